ifetch_page_walker: RTL and testbench

Sv32 hardware page-table walker that serves instruction-side translation misses from the fetch pipeline's page-walk request port. It accepts one virtual-address request at a time and reads level-1 then level-0 PTEs through a single-outstanding memory read port. It returns a leaf PPN with permission bits, or a page fault, as a one-cycle response pulse. It sits between the fetch pipeline's TLB-miss logic and the memory controller's read channel.

---
 rtl/ifetch_page_walker.sv | 203 ++++++++++++++++++++
 tb/tb_ifetch_page_walker.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_page_walker.sv
// Sv32 instruction-side page-table walker: one walk at a time, level-1 then
// level-0 PTE reads over a single-outstanding read port, one-cycle result pulse.
module ifetch_page_walker #(
  parameter int PADDR_W = 34,
  parameter int PPN_W   = 22
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               IN_req_valid,
  input  logic [31:0]        IN_req_vaddr,
  output logic               OUT_req_ready,
  input  logic [PPN_W-1:0]   IN_rootPPN,
  input  logic               IN_flush,
  output logic               OUT_mem_valid,
  output logic [PADDR_W-1:0] OUT_mem_addr,
  input  logic               IN_mem_ready,
  input  logic               IN_mem_rvalid,
  input  logic [31:0]        IN_mem_rdata,
  output logic               OUT_res_valid,
  output logic [19:0]        OUT_res_vpn,
  output logic [PPN_W-1:0]   OUT_res_ppn,
  output logic               OUT_res_super,
  output logic               OUT_res_fault,
  output logic [4:0]         OUT_res_perm
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L1_REQ  = 3'd1,
    L1_WAIT = 3'd2,
    L0_REQ  = 3'd3,
    L0_WAIT = 3'd4,
    RESP    = 3'd5,
    DRAIN   = 3'd6
  } state_t;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  state_t state_q, state_d;

  logic [19:0]        vpn_q;
  logic [PADDR_W-1:0] addr_q;
  logic [PADDR_W-1:0] addr_d;
  logic               addr_load;
  logic               accept;

  logic               res_load;
  logic [PPN_W-1:0]   res_ppn_d;
  logic               res_super_d;
  logic               res_fault_d;
  logic [4:0]         res_perm_d;

  // PTE decode, shared by both levels
  pte_t pte;
  logic pte_invalid;
  logic pte_leaf;
  logic l1_fault;
  logic l0_fault;
  logic [4:0] pte_perm;

  assign pte         = pte_t'(IN_mem_rdata);
  assign pte_invalid = !pte.v || (!pte.r && pte.w);
  assign pte_leaf    = pte.r || pte.x;
  assign l1_fault    = pte_invalid || (pte_leaf && ((pte.ppn0 != 10'd0) || !pte.a));
  assign l0_fault    = pte_invalid || !pte_leaf || !pte.a;
  assign pte_perm    = {pte.u, pte.x, pte.w, pte.r, pte.g};

  // Page offset, reserved-for-software bits and D play no part in an ifetch walk.
  logic unused_bits;
  assign unused_bits = ^{IN_req_vaddr[11:0], pte.rsw, pte.d};

  // NOTE: state register uses non-blocking assignment so every flop samples
  // the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every variable driven here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    addr_load   = 1'b0;
    addr_d      = '0;
    res_load    = 1'b0;
    res_ppn_d   = '0;
    res_super_d = 1'b0;
    res_fault_d = 1'b0;
    res_perm_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (IN_req_valid && !IN_flush) begin
          accept    = 1'b1;
          addr_load = 1'b1;
          addr_d    = {IN_rootPPN, IN_req_vaddr[31:22], 2'b00};
          state_d   = L1_REQ;
        end
      end

      // A handshake that completes under flush still owes us one rvalid.
      L1_REQ: begin
        if (IN_mem_ready)  state_d = IN_flush ? DRAIN : L1_WAIT;
        else if (IN_flush) state_d = IDLE;
      end

      L1_WAIT: begin
        if (IN_mem_rvalid) begin
          if (IN_flush) begin
            state_d = IDLE;
          end else if (l1_fault) begin
            res_load    = 1'b1;
            res_fault_d = 1'b1;
            state_d     = RESP;
          end else if (pte_leaf) begin
            res_load    = 1'b1;
            res_super_d = 1'b1;
            res_ppn_d   = {pte.ppn1, vpn_q[9:0]};
            res_perm_d  = pte_perm;
            state_d     = RESP;
          end else begin
            addr_load = 1'b1;
            addr_d    = {pte.ppn1, pte.ppn0, vpn_q[9:0], 2'b00};
            state_d   = L0_REQ;
          end
        end else if (IN_flush) begin
          state_d = DRAIN;
        end
      end

      L0_REQ: begin
        if (IN_mem_ready)  state_d = IN_flush ? DRAIN : L0_WAIT;
        else if (IN_flush) state_d = IDLE;
      end

      L0_WAIT: begin
        if (IN_mem_rvalid) begin
          if (IN_flush) begin
            state_d = IDLE;
          end else begin
            res_load    = 1'b1;
            res_fault_d = l0_fault;
            res_ppn_d   = l0_fault ? '0 : {pte.ppn1, pte.ppn0};
            res_perm_d  = l0_fault ? '0 : pte_perm;
            state_d     = RESP;
          end
        end else if (IN_flush) begin
          state_d = DRAIN;
        end
      end

      RESP:  state_d = IDLE;

      DRAIN: if (IN_mem_rvalid) state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: all datapath registers take the async reset so outputs read zero
  // immediately, even mid-walk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpn_q         <= '0;
      addr_q        <= '0;
      OUT_res_vpn   <= '0;
      OUT_res_ppn   <= '0;
      OUT_res_super <= 1'b0;
      OUT_res_fault <= 1'b0;
      OUT_res_perm  <= '0;
    end else begin
      if (accept)    vpn_q  <= IN_req_vaddr[31:12];
      if (addr_load) addr_q <= addr_d;
      if (res_load) begin
        OUT_res_vpn   <= vpn_q;
        OUT_res_ppn   <= res_ppn_d;
        OUT_res_super <= res_super_d;
        OUT_res_fault <= res_fault_d;
        OUT_res_perm  <= res_perm_d;
      end
    end
  end

  // Memory-side outputs depend only on state and registers.
  assign OUT_req_ready = (state_q == IDLE);
  assign OUT_mem_valid = (state_q == L1_REQ) || (state_q == L0_REQ);
  assign OUT_mem_addr  = addr_q;
  assign OUT_res_valid = (state_q == RESP) && !IN_flush;

endmodule

// File: tb/tb_ifetch_page_walker.sv
// Directed bench for ifetch_page_walker: hand-computed Sv32 walks, faults,
// flush, stall and reset scenarios.
module tb_ifetch_page_walker;

  localparam int PADDR_W = 34;
  localparam int PPN_W   = 22;

  logic               clk;
  logic               rst;
  logic               IN_req_valid;
  logic [31:0]        IN_req_vaddr;
  logic               OUT_req_ready;
  logic [PPN_W-1:0]   IN_rootPPN;
  logic               IN_flush;
  logic               OUT_mem_valid;
  logic [PADDR_W-1:0] OUT_mem_addr;
  logic               IN_mem_ready;
  logic               IN_mem_rvalid;
  logic [31:0]        IN_mem_rdata;
  logic               OUT_res_valid;
  logic [19:0]        OUT_res_vpn;
  logic [PPN_W-1:0]   OUT_res_ppn;
  logic               OUT_res_super;
  logic               OUT_res_fault;
  logic [4:0]         OUT_res_perm;

  int n_tests = 0;
  int n_fail  = 0;

  ifetch_page_walker #(.PADDR_W(PADDR_W), .PPN_W(PPN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .IN_req_valid  (IN_req_valid),
    .IN_req_vaddr  (IN_req_vaddr),
    .OUT_req_ready (OUT_req_ready),
    .IN_rootPPN    (IN_rootPPN),
    .IN_flush      (IN_flush),
    .OUT_mem_valid (OUT_mem_valid),
    .OUT_mem_addr  (OUT_mem_addr),
    .IN_mem_ready  (IN_mem_ready),
    .IN_mem_rvalid (IN_mem_rvalid),
    .IN_mem_rdata  (IN_mem_rdata),
    .OUT_res_valid (OUT_res_valid),
    .OUT_res_vpn   (OUT_res_vpn),
    .OUT_res_ppn   (OUT_res_ppn),
    .OUT_res_super (OUT_res_super),
    .OUT_res_fault (OUT_res_fault),
    .OUT_res_perm  (OUT_res_perm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PADDR_W-1:0] a1;
    logic [PADDR_W-1:0] a2;
    int                 nreads;
    int                 res_cyc;
    bit                 got;
    bit                 changed;
    logic               ready_after;
    logic [19:0]        vpn;
    logic [PPN_W-1:0]   ppn;
    logic               sup;
    logic               fault;
    logic [4:0]         perm;
  } walk_obs_t;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    IN_req_valid  = 1'b0;
    IN_req_vaddr  = '0;
    IN_rootPPN    = '0;
    IN_flush      = 1'b0;
    IN_mem_ready  = 1'b0;
    IN_mem_rvalid = 1'b0;
    IN_mem_rdata  = '0;
  endtask

  // Drives one walk with a zero-wait memory model (optional level-1 stall and
  // one-cycle flush) and records what the DUT did. Called at posedge+1 in IDLE.
  task automatic run_walk(input logic [31:0] vaddr, input logic [PPN_W-1:0] root,
                          input logic [31:0] pte1, input logic [31:0] pte0,
                          input int stall, input int flush_cyc, output walk_obs_t o);
    bit pend = 0;
    bit prev_stall = 0;
    logic [PADDR_W-1:0] prev_addr = '0;
    o = '{default: 0};
    IN_req_vaddr = vaddr;
    IN_rootPPN   = root;
    for (int cyc = 0; cyc < 16 && !o.got; cyc++) begin
      IN_req_valid  = (cyc == 0);
      IN_mem_ready  = (cyc >= 1 + stall);
      IN_flush      = (cyc == flush_cyc);
      IN_mem_rvalid = pend;
      IN_mem_rdata  = pend ? ((o.nreads == 1) ? pte1 : pte0) : 32'h0;
      pend = 0;
      #4;
      if (prev_stall && OUT_mem_addr !== prev_addr) o.changed = 1;
      prev_stall = OUT_mem_valid && !IN_mem_ready;
      prev_addr  = OUT_mem_addr;
      if (OUT_mem_valid && IN_mem_ready) begin
        if (o.nreads == 0) o.a1 = OUT_mem_addr;
        else               o.a2 = OUT_mem_addr;
        o.nreads++;
        pend = 1;
      end
      if (OUT_res_valid === 1'b1) begin
        o.got     = 1;
        o.res_cyc = cyc;
        o.vpn     = OUT_res_vpn;
        o.ppn     = OUT_res_ppn;
        o.sup     = OUT_res_super;
        o.fault   = OUT_res_fault;
        o.perm    = OUT_res_perm;
      end
      next_cycle();
    end
    idle_inputs();
    o.ready_after = OUT_req_ready;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (OUT_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_req_ready: got %b expected 1", OUT_req_ready);
    end
    n_tests++;
    if ({OUT_mem_valid, OUT_mem_addr, OUT_res_valid, OUT_res_vpn, OUT_res_ppn,
         OUT_res_super, OUT_res_fault, OUT_res_perm} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: mem_valid=%b addr=%h res_valid=%b expected all zero",
               OUT_mem_valid, OUT_mem_addr, OUT_res_valid);
    end
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_walk_4k();
    walk_obs_t o;
    run_walk(32'h4000_1234, 22'h00080, 32'h0002_0401, 32'h048D_144B, 0, -1, o);
    n_tests++;
    if (o.a1 !== 34'h0_0008_0400) begin n_fail++; $display("FAIL 4k_l1_addr: got %h expected 80400", o.a1); end
    n_tests++;
    if (o.a2 !== 34'h0_0008_1004) begin n_fail++; $display("FAIL 4k_l0_addr: got %h expected 81004", o.a2); end
    n_tests++;
    if (!o.got || o.res_cyc != 5) begin n_fail++; $display("FAIL 4k_latency: got cycle %0d (seen %0d) expected 5", o.res_cyc, o.got); end
    n_tests++;
    if ({o.vpn, o.ppn, o.sup, o.fault, o.perm} !== {20'h40001, 22'h12345, 1'b0, 1'b0, 5'b01010}) begin
      n_fail++;
      $display("FAIL 4k_result: got vpn=%h ppn=%h super=%b fault=%b perm=%b expected 40001 12345 0 0 01010",
               o.vpn, o.ppn, o.sup, o.fault, o.perm);
    end
    n_tests++;
    if (o.ready_after !== 1'b1) begin n_fail++; $display("FAIL 4k_ready_after: got %b expected 1", o.ready_after); end
  endtask

  task automatic test_superpage();
    walk_obs_t o;
    run_walk(32'h4000_1234, 22'h00080, 32'h0030_004B, 32'h0, 0, -1, o);
    n_tests++;
    if (!o.got || o.res_cyc != 3 || o.nreads != 1) begin
      n_fail++;
      $display("FAIL super_timing: got cycle %0d reads %0d expected cycle 3 reads 1", o.res_cyc, o.nreads);
    end
    n_tests++;
    if ({o.ppn, o.sup, o.fault, o.perm} !== {22'h00C01, 1'b1, 1'b0, 5'b01010}) begin
      n_fail++;
      $display("FAIL super_result: got ppn=%h super=%b fault=%b perm=%b expected 00c01 1 0 01010",
               o.ppn, o.sup, o.fault, o.perm);
    end
  endtask

  task automatic test_faults();
    logic [31:0] p1 [4] = '{32'h0000_0000, 32'h0030_144B, 32'h0002_0401, 32'h0002_0401};
    logic [31:0] p0 [4] = '{32'h0, 32'h0, 32'h048D_140B, 32'h0002_0401};
    int          er [4] = '{1, 1, 2, 2};
    int          ec [4] = '{3, 3, 5, 5};
    walk_obs_t o;
    for (int i = 0; i < 4; i++) begin
      run_walk(32'h4000_1234, 22'h00080, p1[i], p0[i], 0, -1, o);
      n_tests++;
      if (!o.got || o.fault !== 1'b1 || o.res_cyc != ec[i] || o.nreads != er[i]) begin
        n_fail++;
        $display("FAIL fault_%0d: got seen=%0d fault=%b cycle=%0d reads=%0d expected fault=1 cycle=%0d reads=%0d",
                 i, o.got, o.fault, o.res_cyc, o.nreads, ec[i], er[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    walk_obs_t o;
    run_walk(32'h4000_1234, 22'h00080, 32'h0030_004B, 32'h0, 0, -1, o);
    run_walk(32'h8040_3ABC, 22'h00100, 32'h0002_0401, 32'h0ABC_D45B, 0, -1, o);
    n_tests++;
    if (o.a1 !== 34'h0_0010_0804 || o.a2 !== 34'h0_0008_100C) begin
      n_fail++;
      $display("FAIL b2b_addrs: got %h %h expected 100804 8100c", o.a1, o.a2);
    end
    n_tests++;
    if (!o.got || o.res_cyc != 5 ||
        {o.vpn, o.ppn, o.sup, o.fault, o.perm} !== {20'h80403, 22'h2AF35, 1'b0, 1'b0, 5'b11010}) begin
      n_fail++;
      $display("FAIL b2b_result: got cycle=%0d vpn=%h ppn=%h super=%b fault=%b perm=%b expected 5 80403 2af35 0 0 11010",
               o.res_cyc, o.vpn, o.ppn, o.sup, o.fault, o.perm);
    end
  endtask

  task automatic test_flush_l0_wait();
    bit bad_res = 0;
    bit bad_busy = 0;
    walk_obs_t o;
    IN_req_valid = 1'b1; IN_req_vaddr = 32'h4000_1234; IN_rootPPN = 22'h00080;
    next_cycle();
    IN_req_valid = 1'b0; IN_mem_ready = 1'b1;
    next_cycle();
    IN_mem_ready = 1'b0; IN_mem_rvalid = 1'b1; IN_mem_rdata = 32'h0002_0401;
    next_cycle();
    IN_mem_rvalid = 1'b0; IN_mem_ready = 1'b1;
    #1;
    n_tests++;
    if (OUT_mem_valid !== 1'b1 || OUT_mem_addr !== 34'h0_0008_1004) begin
      n_fail++;
      $display("FAIL flush_l0_addr: got valid=%b addr=%h expected 1 81004", OUT_mem_valid, OUT_mem_addr);
    end
    next_cycle();
    IN_mem_ready = 1'b0; IN_flush = 1'b1;
    #1;
    if (OUT_res_valid !== 1'b0) bad_res = 1;
    next_cycle();
    IN_flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      IN_mem_rvalid = (c == 2);
      IN_mem_rdata  = (c == 2) ? 32'h048D_144B : 32'h0;
      #1;
      if (OUT_res_valid !== 1'b0) bad_res = 1;
      if (OUT_req_ready !== 1'b0 || OUT_mem_valid !== 1'b0) bad_busy = 1;
      next_cycle();
    end
    IN_mem_rvalid = 1'b0; IN_mem_rdata = '0;
    #1;
    if (OUT_res_valid !== 1'b0) bad_res = 1;
    n_tests++;
    if (bad_res) begin n_fail++; $display("FAIL flush_l0_no_resp: got a response pulse expected none"); end
    n_tests++;
    if (bad_busy || OUT_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_l0_drain: got busy_err=%0d ready_after=%b expected 0 1", bad_busy, OUT_req_ready);
    end
    next_cycle();
    run_walk(32'h4000_1234, 22'h00080, 32'h0002_0401, 32'h048D_144B, 0, -1, o);
    n_tests++;
    if (!o.got || o.res_cyc != 5 || o.ppn !== 22'h12345 || o.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_l0_rewalk: got cycle=%0d ppn=%h fault=%b expected 5 12345 0", o.res_cyc, o.ppn, o.fault);
    end
  endtask

  task automatic test_mem_stall();
    walk_obs_t o;
    run_walk(32'h4000_1234, 22'h00080, 32'h0030_004B, 32'h0, 4, -1, o);
    n_tests++;
    if (o.changed || o.a1 !== 34'h0_0008_0400) begin
      n_fail++;
      $display("FAIL stall_addr: got changed=%0d addr=%h expected 0 80400", o.changed, o.a1);
    end
    n_tests++;
    if (!o.got || o.res_cyc != 7 || o.nreads != 1 || o.ppn !== 22'h00C01) begin
      n_fail++;
      $display("FAIL stall_result: got cycle=%0d reads=%0d ppn=%h expected 7 1 00c01", o.res_cyc, o.nreads, o.ppn);
    end
  endtask

  task automatic test_flush_stall();
    IN_req_valid = 1'b1; IN_req_vaddr = 32'h4000_1234; IN_rootPPN = 22'h00080;
    next_cycle();
    IN_req_valid = 1'b0;
    next_cycle();
    IN_flush = 1'b1;
    #1;
    n_tests++;
    if (OUT_mem_valid !== 1'b1) begin n_fail++; $display("FAIL flush_stall_valid: got %b expected 1", OUT_mem_valid); end
    next_cycle();
    IN_flush = 1'b0;
    #1;
    n_tests++;
    if (OUT_req_ready !== 1'b1 || OUT_mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall_idle: got ready=%b valid=%b expected 1 0", OUT_req_ready, OUT_mem_valid);
    end
    next_cycle();
  endtask

  task automatic test_flush_idle();
    IN_req_valid = 1'b1; IN_flush = 1'b1; IN_req_vaddr = 32'h4000_1234; IN_rootPPN = 22'h00080;
    next_cycle();
    idle_inputs();
    #1;
    n_tests++;
    if (OUT_req_ready !== 1'b1 || OUT_mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: got ready=%b valid=%b expected 1 0", OUT_req_ready, OUT_mem_valid);
    end
    next_cycle();
  endtask

  task automatic test_flush_resp();
    walk_obs_t o;
    run_walk(32'h4000_1234, 22'h00080, 32'h0030_004B, 32'h0, 0, 3, o);
    n_tests++;
    if (o.got || o.nreads != 1 || o.ready_after !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_resp: got seen=%0d reads=%0d ready=%b expected 0 1 1", o.got, o.nreads, o.ready_after);
    end
  endtask

  task automatic test_reset_mid_walk();
    bit bad = 0;
    IN_req_valid = 1'b1; IN_req_vaddr = 32'h4000_1234; IN_rootPPN = 22'h00080;
    next_cycle();
    IN_req_valid = 1'b0; IN_mem_ready = 1'b1;
    next_cycle();
    IN_mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({OUT_mem_valid, OUT_mem_addr, OUT_res_valid, OUT_res_vpn, OUT_res_ppn,
         OUT_res_super, OUT_res_fault, OUT_res_perm} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got valid=%b addr=%h ppn=%h expected zero", OUT_mem_valid, OUT_mem_addr, OUT_res_ppn);
    end
    next_cycle();
    rst = 1'b1;
    IN_mem_rvalid = 1'b1; IN_mem_rdata = 32'h0030_004B;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (OUT_req_ready !== 1'b1 || OUT_res_valid !== 1'b0 || OUT_mem_valid !== 1'b0) bad = 1;
      next_cycle();
      IN_mem_rvalid = 1'b0; IN_mem_rdata = '0;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL midreset_stale_rvalid: got activity after reset expected idle with ready=1"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_walk_4k();
    test_superpage();
    test_faults();
    test_back_to_back();
    test_flush_l0_wait();
    test_mem_stall();
    test_flush_stall();
    test_flush_idle();
    test_flush_resp();
    test_reset_mid_walk();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
